// File: rtl/video_fb_reader.sv
// Raster framebuffer reader: issues RAM reads ahead, tags pixels with frame/line start, show-ahead FIFO out.
// Read issued the cycle after enable; pixel valid RAM_LATENCY cycles later; reads stop once FIFO + in-flight fill it.
module video_fb_reader #(
  parameter int PIXEL_BITS    = 16,
  parameter int SCREEN_WIDTH  = 128,
  parameter int SCREEN_HEIGHT = 160,
  parameter int ADDR_BITS     = 15,
  parameter int RAM_LATENCY   = 1,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                  in_clk,
  input  logic                  in_rst,
  input  logic                  in_enable,
  input  logic                  in_restart,
  output logic [ADDR_BITS-1:0]  out_mem_addr,
  output logic                  out_mem_rd,
  input  logic [PIXEL_BITS-1:0] in_mem_data,
  output logic [PIXEL_BITS-1:0] out_pixel,
  output logic                  out_pixel_valid,
  input  logic                  in_pixel_ready,
  output logic                  out_frame_start,
  output logic                  out_line_start
);

  localparam int XW = (SCREEN_WIDTH > 1) ? $clog2(SCREEN_WIDTH) : 1;
  localparam int YW = (SCREEN_HEIGHT > 1) ? $clog2(SCREEN_HEIGHT) : 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [XW-1:0]        X_LAST = XW'(SCREEN_WIDTH - 1);
  localparam logic [YW-1:0]        Y_LAST = YW'(SCREEN_HEIGHT - 1);
  localparam logic [ADDR_BITS-1:0] A_LAST = ADDR_BITS'(SCREEN_WIDTH * SCREEN_HEIGHT - 1);

  typedef struct packed {
    logic vld;
    logic fs;
    logic ls;
  } tag_t;

  typedef struct packed {
    logic [PIXEL_BITS-1:0] pix;
    logic                  fs;
    logic                  ls;
  } entry_t;

  logic                 rd_q, rd_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [XW-1:0]        x_q, x_d;
  logic [YW-1:0]        y_q, y_d;
  tag_t                 dl_q [RAM_LATENCY];
  tag_t                 dl_d [RAM_LATENCY];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  entry_t               mem_q [FIFO_DEPTH];
  entry_t               head;
  logic                 push, pop;
  int                   occ;

  always_comb begin
    pop  = (count_q != '0) && in_pixel_ready;
    push = dl_q[RAM_LATENCY-1].vld;

    // Every in-flight read already owns a FIFO slot; only issue when one more is free after this edge.
    occ = int'(count_q) - (pop ? 1 : 0);
    for (int i = 0; i < RAM_LATENCY; i++) occ = occ + (dl_q[i].vld ? 1 : 0);
    rd_d = in_enable && !in_restart && (occ < FIFO_DEPTH);

    addr_d = addr_q;
    x_d    = x_q;
    y_d    = y_q;
    if (in_restart) begin
      addr_d = '0;
      x_d    = '0;
      y_d    = '0;
    end else if (rd_q) begin
      addr_d = (addr_q == A_LAST) ? '0 : addr_q + ADDR_BITS'(1);
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + YW'(1);
      end else begin
        x_d = x_q + XW'(1);
      end
    end

    // Stage 0 is loaded alongside rd_q, so it describes the read at addr_d.
    dl_d[0] = '{vld: rd_d, fs: (x_d == '0) && (y_d == '0), ls: (x_d == '0)};
    for (int i = 1; i < RAM_LATENCY; i++) dl_d[i] = in_restart ? '0 : dl_q[i-1];

    if (in_restart) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      wr_ptr_d = wr_ptr_q + PW'(push);
      rd_ptr_d = rd_ptr_q + PW'(pop);
      count_d  = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      rd_q     <= 1'b0;
      addr_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < RAM_LATENCY; i++) dl_q[i] <= '0;
    end else begin
      rd_q     <= rd_d;
      addr_q   <= addr_d;
      x_q      <= x_d;
      y_q      <= y_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dl_q     <= dl_d;
    end
  end

  always_ff @(posedge in_clk) begin
    if (push && !in_restart) begin
      mem_q[wr_ptr_q] <= '{pix: in_mem_data, fs: dl_q[RAM_LATENCY-1].fs, ls: dl_q[RAM_LATENCY-1].ls};
    end
  end

  // Outputs are gated by the FIFO count so reset clears them without clearing storage.
  assign head            = mem_q[rd_ptr_q];
  assign out_pixel_valid = (count_q != '0);
  assign out_pixel       = out_pixel_valid ? head.pix : '0;
  assign out_frame_start = out_pixel_valid && head.fs;
  assign out_line_start  = out_pixel_valid && head.ls;
  assign out_mem_rd      = rd_q;
  assign out_mem_addr    = addr_q;

endmodule

// File: tb/tb_video_fb_reader.sv
// Bench for video_fb_reader on a 4x4 screen: one DUT with RAM latency 1, one with latency 3.
module tb_video_fb_reader;

  typedef struct packed {
    logic [15:0] pix;
    logic        fs;
    logic        ls;
  } px_t;

  logic        clk;
  logic        rst0, en0, rs0, rdy0, rd0, pv0, fs0, ls0;
  logic [14:0] addr0;
  logic [15:0] mdat0, pix0;
  logic        rst1, en1, rs1, rdy1, rd1, pv1, fs1, ls1;
  logic [14:0] addr1;
  logic [15:0] mdat1, pix1, p1, p2;

  logic        sel;
  logic        m_rd, m_pv, m_rdy, m_fs, m_ls;
  logic [15:0] m_pix;

  px_t exp_q[$];
  px_t obs_q[$];
  int  nxt, n_rd, n_pop, outstanding, max_out;
  int  checks, failures;

  video_fb_reader #(.PIXEL_BITS(16), .SCREEN_WIDTH(4), .SCREEN_HEIGHT(4), .ADDR_BITS(15),
                    .RAM_LATENCY(1), .FIFO_DEPTH(4)) dut0 (
    .in_clk(clk), .in_rst(rst0), .in_enable(en0), .in_restart(rs0),
    .out_mem_addr(addr0), .out_mem_rd(rd0), .in_mem_data(mdat0),
    .out_pixel(pix0), .out_pixel_valid(pv0), .in_pixel_ready(rdy0),
    .out_frame_start(fs0), .out_line_start(ls0));

  video_fb_reader #(.PIXEL_BITS(16), .SCREEN_WIDTH(4), .SCREEN_HEIGHT(4), .ADDR_BITS(15),
                    .RAM_LATENCY(3), .FIFO_DEPTH(4)) dut1 (
    .in_clk(clk), .in_rst(rst1), .in_enable(en1), .in_restart(rs1),
    .out_mem_addr(addr1), .out_mem_rd(rd1), .in_mem_data(mdat1),
    .out_pixel(pix1), .out_pixel_valid(pv1), .in_pixel_ready(rdy1),
    .out_frame_start(fs1), .out_line_start(ls1));

  always #5 clk = ~clk;

  // RAM[a] = a. Latency 1: data in the strobe cycle; latency 3: two cycles later.
  assign mdat0 = 16'(addr0);
  always @(posedge clk) begin
    p1 <= 16'(addr1);
    p2 <= p1;
  end
  assign mdat1 = p2;

  assign m_rd  = sel ? rd1  : rd0;
  assign m_pv  = sel ? pv1  : pv0;
  assign m_rdy = sel ? rdy1 : rdy0;
  assign m_pix = sel ? pix1 : pix0;
  assign m_fs  = sel ? fs1  : fs0;
  assign m_ls  = sel ? ls1  : ls0;

  // Scoreboard feed: each issued read yields the next raster pixel expected; each handshake is recorded.
  always @(negedge clk) begin
    if (m_rd) begin
      exp_q.push_back('{pix: 16'(nxt), fs: (nxt == 0), ls: (nxt % 4 == 0)});
      nxt = (nxt + 1) % 16;
      n_rd++;
      outstanding++;
    end
    if (m_pv && m_rdy) begin
      obs_q.push_back('{pix: m_pix, fs: m_fs, ls: m_ls});
      n_pop++;
      outstanding--;
    end
    if (outstanding > max_out) max_out = outstanding;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst0 = 0; rst1 = 0;
    en0 = 0; en1 = 0; rs0 = 0; rs1 = 0; rdy0 = 0; rdy1 = 0;
    repeat (2) @(posedge clk);
    #1;
    rst0 = 1; rst1 = 1;
    exp_q.delete(); obs_q.delete();
    nxt = 0; n_rd = 0; n_pop = 0; outstanding = 0; max_out = 0;
  endtask

  task automatic test_reset();
    en0 = 0; rs0 = 0; rdy0 = 0; rst0 = 0;
    #2;
    checks++; if (pv0 !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b want 0", pv0); end
    checks++; if (pix0 !== 16'd0) begin failures++; $display("FAIL reset_pixel: got %0d want 0", pix0); end
    checks++; if (fs0 !== 1'b0 || ls0 !== 1'b0) begin failures++; $display("FAIL reset_flags: got fs=%0b ls=%0b want 0 0", fs0, ls0); end
    checks++; if (rd0 !== 1'b0) begin failures++; $display("FAIL reset_rd: got %0b want 0", rd0); end
    checks++; if (addr0 !== 15'd0) begin failures++; $display("FAIL reset_addr: got %0d want 0", addr0); end
  endtask

  task automatic test_stream();
    px_t o, e;
    int gaps;
    do_reset(); sel = 0; en0 = 1; rdy0 = 1;
    step();
    checks++; if (rd0 !== 1'b1) begin failures++; $display("FAIL stream_first_rd: got %0b want 1", rd0); end
    checks++; if (pv0 !== 1'b0) begin failures++; $display("FAIL stream_early_valid: got %0b want 0", pv0); end
    step();
    checks++; if (pv0 !== 1'b1) begin failures++; $display("FAIL stream_latency: valid=%0b want 1 at cycle 2", pv0); end
    checks++; if (pix0 !== 16'd0 || fs0 !== 1'b1 || ls0 !== 1'b1) begin
      failures++; $display("FAIL stream_first_pixel: got pix=%0d fs=%0b ls=%0b want 0 1 1", pix0, fs0, ls0); end
    gaps = 0;
    repeat (36) begin step(); if (pv0 !== 1'b1) gaps++; end
    checks++; if (gaps != 0) begin failures++; $display("FAIL stream_throughput: got %0d gap cycles want 0", gaps); end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); checks++;
      if (exp_q.size() == 0) begin failures++; $display("FAIL stream_order: got pix=%0d, nothing expected", o.pix); end
      else begin e = exp_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL stream_order: got pix=%0d fs=%0b ls=%0b want pix=%0d fs=%0b ls=%0b", o.pix, o.fs, o.ls, e.pix, e.fs, e.ls); end
      end
    end
  endtask

  task automatic test_backpressure();
    px_t o, e;
    int bad, gaps;
    do_reset(); sel = 0; en0 = 1; rdy0 = 0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i >= 2 && (pv0 !== 1'b1 || pix0 !== 16'd0 || fs0 !== 1'b1)) bad++;
    end
    checks++; if (n_rd != 4) begin failures++; $display("FAIL bp_reads: got %0d reads want 4", n_rd); end
    checks++; if (bad != 0) begin failures++; $display("FAIL bp_stable: got %0d unstable cycles want 0", bad); end
    checks++; if (n_pop != 0) begin failures++; $display("FAIL bp_pops: got %0d pops want 0", n_pop); end
    rdy0 = 1; gaps = 0;
    repeat (30) begin step(); if (pv0 !== 1'b1) gaps++; end
    checks++; if (gaps != 0) begin failures++; $display("FAIL bp_resume_gap: got %0d gap cycles want 0", gaps); end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); checks++;
      if (exp_q.size() == 0) begin failures++; $display("FAIL bp_order: got pix=%0d, nothing expected", o.pix); end
      else begin e = exp_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL bp_order: got pix=%0d fs=%0b ls=%0b want pix=%0d fs=%0b ls=%0b", o.pix, o.fs, o.ls, e.pix, e.fs, e.ls); end
      end
    end
  endtask

  task automatic test_latency3();
    px_t o, e;
    do_reset(); sel = 1; en1 = 1;
    for (int i = 0; i < 80; i++) begin rdy1 = i[0]; step(); end
    checks++; if (max_out > 4) begin failures++; $display("FAIL lat3_occupancy: got %0d outstanding want <= 4", max_out); end
    checks++; if (n_pop < 30) begin failures++; $display("FAIL lat3_rate: got %0d pixels want >= 30", n_pop); end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); checks++;
      if (exp_q.size() == 0) begin failures++; $display("FAIL lat3_order: got pix=%0d, nothing expected", o.pix); end
      else begin e = exp_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL lat3_order: got pix=%0d fs=%0b ls=%0b want pix=%0d fs=%0b ls=%0b", o.pix, o.fs, o.ls, e.pix, e.fs, e.ls); end
      end
    end
  endtask

  task automatic test_restart();
    px_t o, e;
    logic found;
    do_reset(); sel = 1; en1 = 1; rdy1 = 1;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin step(); if (rd1 && addr1 == 15'd11) found = 1; end
    checks++; if (!found) begin failures++; $display("FAIL restart_setup: got no read at addr 11 want one"); end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); checks++;
      if (exp_q.size() == 0) begin failures++; $display("FAIL restart_pre_order: got pix=%0d, nothing expected", o.pix); end
      else begin e = exp_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL restart_pre_order: got pix=%0d want pix=%0d", o.pix, e.pix); end
      end
    end
    rs1 = 1; rdy1 = 0;
    step();
    rs1 = 0;
    checks++; if (pv1 !== 1'b0) begin failures++; $display("FAIL restart_flush: got valid=%0b want 0", pv1); end
    checks++; if (rd1 !== 1'b0) begin failures++; $display("FAIL restart_rd: got %0b want 0", rd1); end
    exp_q.delete(); obs_q.delete(); nxt = 0; outstanding = 0;
    rdy1 = 1;
    found = 0;
    for (int i = 0; i < 12 && !found; i++) begin step(); if (pv1) found = 1; end
    checks++; if (!found || pix1 !== 16'd0 || fs1 !== 1'b1) begin
      failures++; $display("FAIL restart_first: got valid=%0b pix=%0d fs=%0b want 1 0 1", pv1, pix1, fs1); end
    repeat (20) step();
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); checks++;
      if (exp_q.size() == 0) begin failures++; $display("FAIL restart_order: got pix=%0d, nothing expected", o.pix); end
      else begin e = exp_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL restart_order: got pix=%0d fs=%0b ls=%0b want pix=%0d fs=%0b ls=%0b", o.pix, o.fs, o.ls, e.pix, e.fs, e.ls); end
      end
    end
  endtask

  task automatic test_enable_gap();
    px_t o, e;
    logic found;
    do_reset(); sel = 0; en0 = 1; rdy0 = 1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin step(); if (rd0 && addr0 == 15'd5) found = 1; end
    en0 = 0;
    checks++; if (!found) begin failures++; $display("FAIL gap_setup: got no read at addr 5 want one"); end
    repeat (10) step();
    checks++; if (n_rd != 6) begin failures++; $display("FAIL gap_reads: got %0d reads want 6", n_rd); end
    checks++; if (n_pop != 6) begin failures++; $display("FAIL gap_delivered: got %0d pixels want 6", n_pop); end
    checks++; if (addr0 !== 15'd6) begin failures++; $display("FAIL gap_addr_hold: got %0d want 6", addr0); end
    checks++; if (pv0 !== 1'b0) begin failures++; $display("FAIL gap_drained: got valid=%0b want 0", pv0); end
    en0 = 1;
    repeat (12) step();
    checks++; if (n_rd <= 6) begin failures++; $display("FAIL gap_resume: got %0d reads want > 6", n_rd); end
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front(); checks++;
      if (exp_q.size() == 0) begin failures++; $display("FAIL gap_order: got pix=%0d, nothing expected", o.pix); end
      else begin e = exp_q.pop_front();
        if (o !== e) begin failures++; $display("FAIL gap_order: got pix=%0d fs=%0b ls=%0b want pix=%0d fs=%0b ls=%0b", o.pix, o.fs, o.ls, e.pix, e.fs, e.ls); end
      end
    end
  endtask

  task automatic test_async_reset();
    do_reset(); sel = 0; en0 = 1; rdy0 = 1;
    repeat (7) step();
    #2;
    rst0 = 0;
    #1;
    checks++; if (pv0 !== 1'b0) begin failures++; $display("FAIL arst_valid: got %0b want 0", pv0); end
    checks++; if (pix0 !== 16'd0) begin failures++; $display("FAIL arst_pixel: got %0d want 0", pix0); end
    checks++; if (fs0 !== 1'b0 || ls0 !== 1'b0) begin failures++; $display("FAIL arst_flags: got fs=%0b ls=%0b want 0 0", fs0, ls0); end
    checks++; if (rd0 !== 1'b0) begin failures++; $display("FAIL arst_rd: got %0b want 0", rd0); end
    checks++; if (addr0 !== 15'd0) begin failures++; $display("FAIL arst_addr: got %0d want 0", addr0); end
    en0 = 0; rdy0 = 0;
    step();
  endtask

  initial begin
    clk = 0; sel = 0;
    rst0 = 0; rst1 = 0; en0 = 0; en1 = 0; rs0 = 0; rs1 = 0; rdy0 = 0; rdy1 = 0;
    nxt = 0; n_rd = 0; n_pop = 0; outstanding = 0; max_out = 0;
    checks = 0; failures = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_latency3();
    test_restart();
    test_enable_gap();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
